// File: rtl/uart_program_loader.sv
// UART (8N1) program loader: receives a framed 16-byte image and writes it through the manual programming path.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int MEM_DEPTH   = 16,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [7:0]                   mem_data,
  output logic                         mem_we,
  output logic                         loading,
  output logic                         load_done,
  output logic                         load_err,
  output logic                         cpu_rst
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int AW   = $clog2(MEM_DEPTH);
  localparam int ACW  = AW + 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [2:0] {
    F_WAIT_HDR, F_LOAD,
`ifdef LOADER_CHECKSUM_EN
    F_CSUM,
`endif
    F_OK, F_FAIL
  } f_state_t;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  // byte_valid/frame_err are single-cycle strobes with no ready: the frame FSM
  // must consume them in the cycle they are high (valid-only, no backpressure).
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  f_state_t        f_state_q, f_state_d;
  logic [ACW-1:0]  addr_cnt_q, addr_cnt_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            ok_pend_q, ok_pend_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_data_q, mem_data_d;
  logic            mem_we_q, mem_we_d;
  logic            loading_q, loading_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;
  logic            cpu_rst_q, cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif
  logic            timed_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (bit_cnt_q == CW'(HALF - 1)) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == CW'(CPB - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == CW'(CPB - 1)) begin
          bit_cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_BREAK;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_BREAK: if (rx_sync_q) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  assign timed_out = (idle_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    f_state_d   = f_state_q;
    addr_cnt_d  = addr_cnt_q;
    idle_d      = idle_q;
    ok_pend_d   = 1'b0;
    cpu_rst_d   = ok_pend_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    loading_d   = loading_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (f_state_q)
      F_WAIT_HDR: begin
        if (byte_valid_q && shift_q == 8'hA5) begin
          loading_d   = 1'b1;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          addr_cnt_d  = '0;
          idle_d      = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
          f_state_d   = F_LOAD;
        end
      end
      F_LOAD: begin
        if (frame_err_q) begin
          f_state_d = F_FAIL;
        end else if (byte_valid_q) begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_cnt_q[AW-1:0];
          mem_data_d = shift_q;
          addr_cnt_d = addr_cnt_q + 1'b1;
          idle_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q + shift_q;
          if (addr_cnt_q == ACW'(MEM_DEPTH - 1)) f_state_d = F_CSUM;
`else
          if (addr_cnt_q == ACW'(MEM_DEPTH - 1)) f_state_d = F_OK;
`endif
        end else if (timed_out) begin
          f_state_d = F_FAIL;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      F_CSUM: begin
        if (frame_err_q) begin
          f_state_d = F_FAIL;
        end else if (byte_valid_q) begin
          f_state_d = (shift_q == csum_q) ? F_OK : F_FAIL;
        end else if (timed_out) begin
          f_state_d = F_FAIL;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
`endif
      F_OK: begin
        loading_d   = 1'b0;
        load_done_d = 1'b1;
        ok_pend_d   = 1'b1;
        f_state_d   = F_WAIT_HDR;
      end
      F_FAIL: begin
        loading_d  = 1'b0;
        load_err_d = 1'b1;
        f_state_d  = F_WAIT_HDR;
      end
      default: f_state_d = F_WAIT_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      f_state_q    <= F_WAIT_HDR;
      addr_cnt_q   <= '0;
      idle_q       <= '0;
      ok_pend_q    <= 1'b0;
      cpu_rst_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      loading_q    <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      f_state_q    <= f_state_d;
      addr_cnt_q   <= addr_cnt_d;
      idle_q       <= idle_d;
      ok_pend_q    <= ok_pend_d;
      cpu_rst_q    <= cpu_rst_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      loading_q    <= loading_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign loading   = loading_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: good/bad frames, framing error, glitch, timeout, mid-frame reset.
module tb_uart_program_loader;

  localparam int CPB = 10;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we, loading, load_done, load_err, cpu_rst;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int cpu_cnt = 0;
  logic [11:0] exp_q[$];
  logic ld_p1 = 1'b0, ld_p2 = 1'b0, we_p1 = 1'b0;

  uart_program_loader #(
    .CLK_HZ(1000), .BAUD(100), .MEM_DEPTH(16), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .loading(loading), .load_done(load_done), .load_err(load_err),
    .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {mem_addr, mem_data, mem_we, loading, load_done, load_err, cpu_rst}, 0);
  endtask

  // Scoreboard and protocol monitor on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_cnt++;
        check("we_width", {31'd0, we_p1}, 0);
        if (exp_q.size() == 0) check("we_unexpected", {20'd0, mem_addr, mem_data}, 32'hFFF);
        else check("we_addr_data", {20'd0, mem_addr, mem_data}, {20'd0, exp_q.pop_front()});
      end
      if (cpu_rst) begin
        cpu_cnt++;
        check("cpu_rst_timing", {29'd0, ld_p2, ld_p1, loading}, 3'b100);
      end
      if (ld_p1 && !loading) check("fall_flag", {31'd0, load_done | load_err}, 1);
    end
    ld_p2 = ld_p1;
    ld_p1 = loading;
    we_p1 = mem_we;
  end

  int we0, cpu0;
  logic [7:0] d;

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    settle(3);
    check_reset_outs("reset_outs");
    rst = 1'b0;
    settle(200);
    check("idle_no_we", we_cnt, 0);
    check_reset_outs("idle_outs");

    // Good frame 0x00..0x0F, checksum 0x78
    we0 = we_cnt; cpu0 = cpu_cnt;
    for (int i = 0; i < 16; i++) exp_q.push_back({i[3:0], i[7:0]});
    send_byte(8'hA5, 1'b1);
    settle(1);
    check("hdr_loading", {31'd0, loading}, 1);
    for (int i = 0; i < 16; i++) send_byte(i[7:0], 1'b1);
    send_byte(8'h78, 1'b1);
    settle(20);
    check("good_writes", we_cnt - we0, 16);
    check("good_flags", {29'd0, loading, load_done, load_err}, 3'b010);
    check("good_cpu_rst", cpu_cnt - cpu0, 1);
    check("good_sb_empty", exp_q.size(), 0);

    // Same frame, bad checksum 0x79
    we0 = we_cnt; cpu0 = cpu_cnt;
    for (int i = 0; i < 16; i++) exp_q.push_back({i[3:0], i[7:0]});
    send_byte(8'hA5, 1'b1);
    settle(1);
    check("hdr_clears_done", {30'd0, load_done, load_err}, 0);
    for (int i = 0; i < 16; i++) send_byte(i[7:0], 1'b1);
    send_byte(8'h79, 1'b1);
    settle(20);
    check("badcs_writes", we_cnt - we0, 16);
`ifdef LOADER_CHECKSUM_EN
    check("badcs_flags", {29'd0, loading, load_done, load_err}, 3'b001);
    check("badcs_cpu_rst", cpu_cnt - cpu0, 0);
`else
    check("badcs_flags", {29'd0, loading, load_done, load_err}, 3'b010);
    check("badcs_cpu_rst", cpu_cnt - cpu0, 1);
`endif

    // Framing error after 3 data bytes
    we0 = we_cnt; cpu0 = cpu_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back({i[3:0], 8'h10 + i[7:0]});
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h10 + i[7:0], 1'b1);
    send_byte(8'h55, 1'b0);
    settle(30);
    check("ferr_writes", we_cnt - we0, 3);
    check("ferr_flags", {29'd0, loading, load_done, load_err}, 3'b001);
    check("ferr_cpu_rst", cpu_cnt - cpu0, 0);

    // Glitch inside LOAD, then silence until timeout
    we0 = we_cnt;
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    settle(50);
    check("glitch_no_we", we_cnt - we0, 0);
    check("glitch_loading", {29'd0, loading, load_done, load_err}, 3'b100);
    settle(TMO);
    check("tmo_flags", {29'd0, loading, load_done, load_err}, 3'b001);
    check("tmo_no_we", we_cnt - we0, 0);

    // Reset after 5th data byte, then full frame with 0xA5 as first data byte
    we0 = we_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back({i[3:0], 8'h20 + i[7:0]});
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'h20 + i[7:0], 1'b1);
    settle(0);
    check("mid_writes", we_cnt - we0, 5);
    @(posedge clk);
    rst = 1'b1;
    settle(3);
    check_reset_outs("mid_rst_outs");
    rst = 1'b0;
    settle(20);
    check_reset_outs("post_rst_outs");

    we0 = we_cnt; cpu0 = cpu_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) begin
      d = (i == 0) ? 8'hA5 : i[7:0];
      exp_q.push_back({i[3:0], d});
      send_byte(d, 1'b1);
    end
    send_byte(8'h1D, 1'b1);
    settle(20);
    check("final_writes", we_cnt - we0, 16);
    check("final_flags", {29'd0, loading, load_done, load_err}, 3'b010);
    check("final_cpu_rst", cpu_cnt - cpu0, 1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
